// File: rtl/gmii_tx_arbiter.sv
// Two-requester arbiter for the shared GMII transmit path, with registered output mux and inter-frame gap.
// Optional round-robin tie-break when GMII_ARB_RR_EN is defined; fixed priority (req0 wins) otherwise.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  output logic       gnt0,
  input  logic       tx_en0,
  input  logic [7:0] txd0,
  input  logic       req1,
  output logic       gnt1,
  input  logic       tx_en1,
  input  logic [7:0] txd1,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       grant_timeout,
  output logic [1:0] dbg_state
);

  // Handshake: req is a level held until the frame is done; gnt rises one cycle after req is seen
  // in IDLE; the owner may raise tx_en in any cycle it sees gnt, and a frame ends at the first low tx_en.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_IFG   = 2'd3;

  localparam logic [9:0] TO_LAST  = 10'(GRANT_TIMEOUT - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  logic [1:0] state, state_next;
  logic       sel;
  logic [9:0] to_cnt;
  logic [7:0] ifg_cnt;
  logic       req_g, tx_en_g;
  logic [7:0] txd_g;
  logic       win, path_open, timeout_hit;

  assign req_g   = sel ? req1   : req0;
  assign tx_en_g = sel ? tx_en1 : tx_en0;
  assign txd_g   = sel ? txd1   : txd0;

`ifdef GMII_ARB_RR_EN
  logic last;

  // On a tie the requester that was not served last wins; starts at 1 so req0 wins the first tie.
  assign win = (req0 && req1) ? ~last : ~req0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == S_IDLE && (req0 || req1)) begin
      last <= win;
    end
  end
`else
  assign win = ~req0;
`endif

  assign path_open   = (state == S_GRANT) || (state == S_SEND);
  assign timeout_hit = (state == S_GRANT) && !tx_en_g && req_g && (to_cnt == TO_LAST);
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req0 || req1) state_next = S_GRANT;
      S_GRANT: begin
        if (tx_en_g)                  state_next = S_SEND;
        else if (!req_g)              state_next = S_IDLE;
        else if (to_cnt == TO_LAST)   state_next = S_IDLE;
      end
      S_SEND:  if (!tx_en_g) state_next = S_IFG;
      S_IFG:   if (ifg_cnt == IFG_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sel           <= 1'b0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      to_cnt        <= '0;
      ifg_cnt       <= '0;
      gmii_tx_en    <= 1'b0;
      gmii_txd      <= 8'h00;
      grant_timeout <= 1'b0;
    end else begin
      state         <= state_next;
      grant_timeout <= timeout_hit;

      if (state == S_IDLE && state_next == S_GRANT) begin
        sel  <= win;
        gnt0 <= ~win;
        gnt1 <= win;
      end else if (state_next == S_IDLE || state_next == S_IFG) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
      end

      // Counters sit at zero outside their state, so they start from zero on entry and saturate.
      if (state != S_GRANT)      to_cnt <= '0;
      else if (to_cnt != '1)     to_cnt <= to_cnt + 10'd1;

      if (state != S_IFG)        ifg_cnt <= '0;
      else if (ifg_cnt != '1)    ifg_cnt <= ifg_cnt + 8'd1;

      gmii_tx_en <= tx_en_g && path_open;
      gmii_txd   <= (tx_en_g && path_open) ? txd_g : 8'h00;
    end
  end

endmodule
